// File: rtl/scan_mux_pkg.sv
// Shared types and the round-robin channel search used by scan-based blocks.
package scan_mux_pkg;

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1} scan_mode_t;

  localparam int MAX_CHANNELS = 32;

  // First enabled channel after cur, searching upward and wrapping through 0.
  // Returns cur when it is the only enabled channel or nothing is enabled.
  // An out-of-range cur starts the search at channel 0.
  function automatic int next_enabled(input logic [MAX_CHANNELS-1:0] mask,
                                      input int cur, input int nch);
    int   base;
    int   idx;
    logic found;
    next_enabled = cur;
    found        = 1'b0;
    base         = (cur >= nch) ? nch - 1 : cur;
    for (int i = 1; i <= MAX_CHANNELS; i++) begin
      idx = (base + i) % nch;
      if (!found && (i <= nch) && mask[idx]) begin
        found        = 1'b1;
        next_enabled = idx;
      end
    end
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Control/data bundle between a channel source and the scan multiplexer.
interface scan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic                      mode;
  logic [SELW-1:0]           sel_in;
  logic [CHANNELS-1:0]       enable_mask;
  logic [CHANNELS*WIDTH-1:0] data_in;

  // valid qualifies data_out/sel_out/onehot_out in the same cycle; there is
  // no ready: the consumer must take every word, the mux never stalls.
  logic [WIDTH-1:0]          data_out;
  logic [SELW-1:0]           sel_out;
  logic [CHANNELS-1:0]       onehot_out;
  logic                      valid;

  modport master (
    output mode, sel_in, enable_mask, data_in,
    input  data_out, sel_out, onehot_out, valid
  );

  modport slave (
    input  mode, sel_in, enable_mask, data_in,
    output data_out, sel_out, onehot_out, valid
  );

endinterface

// File: rtl/scan_mux_tick_gen.sv
// Scan prescaler: one-cycle tick every DIVIDE clocks, held at zero while cleared.
module tick_gen #(
  parameter int DIVIDE = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = $clog2(DIVIDE) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Gated by clear so the first AUTO cycle never steps, even with DIVIDE=1.
  assign tick = (r_count == LAST) && !clear;

endmodule

// File: rtl/scan_mux.sv
// N-channel registered multiplexer with manual select or masked round-robin auto-scan.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIVIDE   = 100000
) (
  input logic       clk,
  input logic       reset,
  scan_mux_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);

  scan_mode_t          w_mode;
  scan_mode_t          r_mode_prev;
  logic [SELW-1:0]     r_cur_sel;
  logic [SELW-1:0]     w_sel_nxt;
  logic [SELW-1:0]     w_seek;
  logic                w_cur_enabled;
  logic                w_clear;
  logic                w_tick;
  logic                w_valid;
  logic [WIDTH-1:0]    w_word;
  logic [CHANNELS-1:0] w_onehot;

  logic [WIDTH-1:0]    r_data_out;
  logic [SELW-1:0]     r_sel_out;
  logic [CHANNELS-1:0] r_onehot_out;
  logic                r_valid;

  assign w_mode  = scan_mode_t'(bus.mode);
  assign w_clear = (w_mode == MODE_MANUAL) || (r_mode_prev == MODE_MANUAL);

  tick_gen #(.DIVIDE(DIVIDE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  assign w_seek = SELW'(next_enabled(MAX_CHANNELS'(bus.enable_mask),
                                     int'(r_cur_sel), CHANNELS));
  assign w_cur_enabled = (int'(r_cur_sel) < CHANNELS) && bus.enable_mask[r_cur_sel];

  // A masked current channel is left immediately, without waiting for a tick.
  always_comb begin
    w_sel_nxt = r_cur_sel;
    w_valid   = 1'b0;
    if (w_mode == MODE_MANUAL) begin
      w_sel_nxt = bus.sel_in;
      w_valid   = int'(bus.sel_in) < CHANNELS;
    end else if (|bus.enable_mask) begin
      w_valid = 1'b1;
      if (!w_cur_enabled || w_tick) begin
        w_sel_nxt = w_seek;
      end
    end
  end

  // The output stage samples the channel chosen this edge, so a select change
  // and a data change both appear one clock later.
  always_comb begin
    w_word   = '0;
    w_onehot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_valid && (w_sel_nxt == SELW'(k))) begin
        w_word      = bus.data_in[k*WIDTH +: WIDTH];
        w_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_sel    <= '0;
      r_mode_prev  <= MODE_MANUAL;
      r_data_out   <= '0;
      r_sel_out    <= '0;
      r_onehot_out <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_cur_sel    <= w_sel_nxt;
      r_mode_prev  <= w_mode;
      r_data_out   <= w_word;
      r_sel_out    <= w_sel_nxt;
      r_onehot_out <= w_onehot;
      r_valid      <= w_valid;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.sel_out    = r_sel_out;
  assign bus.onehot_out = r_onehot_out;
  assign bus.valid      = r_valid;

endmodule
